bus_read_mux: RTL and testbench
===============================

Name: bus_read_mux

Overview:
- Parametrised, registered read-return multiplexer for the microcontroller data bus.
- Selects one of NUM_SLAVES peripheral read channels (RAM, UART, switches, gauss, and later additions).
- Waits for that slave's valid strobe, returns the word to the core's DataIn path with a one-cycle valid pulse, and flags errors for bad selects or timeouts.
- Replaces the purely combinational read select; no latches, and data_o holds its value between reads.

Parameters:
- NUM_SLAVES, 4, number of peripheral read channels (2..16).
- DATA_W, 32, read data width.
- SEL_W, $clog2(NUM_SLAVES) (minimum 1), select width; derived, do not override.
- TIMEOUT, 15, maximum WAIT cycles before an error response (1..255).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset
- sel_i  in  SEL_W  slave index for the read
- read_i  in  1  read request; sampled only in IDLE
- slave_data_i  in  NUM_SLAVES*DATA_W  packed slave read words; slave k occupies bits [k*DATA_W +: DATA_W]
- slave_valid_i  in  NUM_SLAVES  per-slave read-data-valid
- data_o  out  DATA_W  returned read word (DataIn_i of core)
- valid_o  out  1  one-cycle pulse: data_o/err_o are valid
- busy_o  out  1  request outstanding
- err_o  out  1  error response qualifier, meaningful with valid_o

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - state=IDLE; data_o=0, valid_o=0, busy_o=0, err_o=0; timeout counter=0.
  - Any pending request is dropped; reset mid-WAIT produces no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - read_i=1 and sel_i<NUM_SLAVES → capture sel_q; go to WAIT.
  - read_i=1 and sel_i>=NUM_SLAVES (only possible when NUM_SLAVES is not a power of 2) → go directly to RESP with err_o=1 and data_o=ERR_WORD.
- WAIT:
  - busy_o=1.
  - slave_valid_i[sel_q]=1 → latch slave_data_i[sel_q], err_o=0; go to RESP.
  - Valid strobes of other slaves are ignored.
  - Counter increments each WAIT cycle without valid. When the counter equals TIMEOUT → data_o=ERR_WORD, err_o=1; go to RESP.
  - Valid arriving in the same cycle the counter reaches TIMEOUT: valid wins, giving a normal response.
- RESP:
  - valid_o=1 for exactly one cycle; busy_o=0.
  - Return to IDLE; counter cleared.
  - read_i during RESP is ignored and must be re-asserted in IDLE.
- Latency: request accepted at edge N; valid seen at edge M (M≥N+1); valid_o high during cycle M+1. Minimum request-to-valid_o is 2 cycles.
- data_o holds its last value in all states except the transition into RESP. err_o is cleared on leaving RESP.
- read_i held high in IDLE continuously starts back-to-back reads; peak throughput is one read per 3 cycles.
- sel_i changes after acceptance have no effect, because sel_q is used.

Optional Feature:
- Macro BUS_READ_MUX_TIMEOUT_EN.
- Defined: timeout counter and timeout error path as described.
- Undefined:
  - No counter is instantiated and TIMEOUT is unused.
  - WAIT persists until the selected valid arrives; only a bad select can raise err_o.

Decomposition:
- Package bus_read_pkg:
  - state enum rd_state_e {IDLE, WAIT, RESP}
  - ERR_WORD = 32'hDEAD_BEEF, zero-extended or truncated to DATA_W
  - default parameter constants
  - slave index constants SLV_RAM=0, SLV_UART=1, SLV_SW=2, SLV_GAUSS=3
- Sub-module read_timeout_ctr:
  - Ports clk_i, rst_ni, clr_i, en_i, expired_o.
  - Parameter TIMEOUT.
  - Instantiated only under BUS_READ_MUX_TIMEOUT_EN.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles → data_o=0, valid_o=0, busy_o=0, err_o=0. No valid_o while read_i=0.
- Normal read, zero wait: sel_i=1, read_i pulse. slave_valid_i[1]=1 with UART word 32'h0000_0041 on the next cycle → valid_o pulse 2 cycles after the request; data_o=32'h41; err_o=0.
- Wait states and stray valids: sel_i=2; slave_valid_i[0] asserted during WAIT (ignored); slave_valid_i[2] asserted 5 cycles later with 32'h0000_00A5 → data_o=32'hA5. busy_o=1 throughout WAIT.
- Timeout (macro defined, TIMEOUT=15): sel_i=3, no valid → after 15 WAIT cycles valid_o=1, err_o=1, data_o=32'hDEAD_BEEF. Repeat with valid arriving in the 15th WAIT cycle → normal data.
- Bad select (NUM_SLAVES=3): sel_i=3, read_i → RESP next cycle with err_o=1, data_o=ERR_WORD.
- Reset mid-WAIT: assert rst_ni=0 during WAIT → IDLE, no valid_o. Next read of slave 0 (32'h1234_5678) completes normally.

Source files
------------

// File: rtl/bus_read_pkg.sv
// Shared types and constants for the bus read-return multiplexer.
package bus_read_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rd_state_e;

  localparam int unsigned DEF_NUM_SLAVES = 4;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_TIMEOUT    = 15;

  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  localparam int unsigned SLV_RAM   = 0;
  localparam int unsigned SLV_UART  = 1;
  localparam int unsigned SLV_SW    = 2;
  localparam int unsigned SLV_GAUSS = 3;

endpackage

// File: rtl/read_timeout_ctr.sv
// Counts WAIT cycles without a valid strobe; expired_o flags the TIMEOUT-th such cycle.
module read_timeout_ctr
  import bus_read_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      cnt_q <= 8'd0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Fires during the cycle in which the count would reach TIMEOUT.
  assign expired_o = en_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/bus_read_mux.sv
// Registered read-return mux: selects one slave, waits for its valid, returns one pulse.
// Optional WAIT timeout enabled by defining BUS_READ_MUX_TIMEOUT_EN.
module bus_read_mux
  import bus_read_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  localparam int unsigned SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [SEL_W-1:0]             sel_i,
  input  logic                         read_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] slave_data_i,
  input  logic [NUM_SLAVES-1:0]        slave_valid_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         valid_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam logic [DATA_W-1:0] ErrWordW = DATA_W'(ERR_WORD);

  rd_state_e         state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              err_q;

  logic              sel_ok;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              expired;

  assign sel_ok = 32'(sel_i) < NUM_SLAVES;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_data  = slave_data_i[k*DATA_W +: DATA_W];
        sel_valid = slave_valid_i[k];
      end
    end
  end

`ifdef BUS_READ_MUX_TIMEOUT_EN
  read_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_q != WAIT),
    .en_i     ((state_q == WAIT) && !sel_valid),
    .expired_o(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (read_i) begin
            if (sel_ok) begin
              sel_q   <= sel_i;
              busy_q  <= 1'b1;
              state_q <= WAIT;
            end else begin
              data_q  <= ErrWordW;
              err_q   <= 1'b1;
              valid_q <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        WAIT: begin
          // A valid strobe beats an expiry landing in the same cycle.
          if (sel_valid) begin
            data_q  <= sel_data;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= RESP;
          end else if (expired) begin
            data_q  <= ErrWordW;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= RESP;
          end
        end
        RESP: begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bus_read_mux.sv
// Bench for bus_read_mux (NUM_SLAVES=3): transaction-level model plus pinned literal checks.
module tb_bus_read_mux;
  import bus_read_pkg::*;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int TO = 15;
`ifdef BUS_READ_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             read;
  logic [SW-1:0]    sel;
  logic [NS*DW-1:0] sdata;
  logic [NS-1:0]    svalid;
  logic [DW-1:0]    data;
  logic             valid;
  logic             busy;
  logic             err;

  bus_read_mux #(
    .NUM_SLAVES(NS),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sel_i        (sel),
    .read_i       (read),
    .slave_data_i (sdata),
    .slave_valid_i(svalid),
    .data_o       (data),
    .valid_o      (valid),
    .busy_o       (busy),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: one outstanding request, a wait count, a pending response.
  bit          m_pend, m_resp;
  int          m_sel, m_waited;
  logic        e_valid, e_busy, e_err;
  logic [31:0] e_data;

  function automatic logic [31:0] slave_word(input int k);
    return sdata[k*DW +: DW];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend <= 0; m_resp <= 0; m_waited <= 0;
      e_valid <= 0; e_busy <= 0; e_err <= 0; e_data <= '0;
    end else if (m_resp) begin
      m_resp <= 0; e_valid <= 0; e_err <= 0;
    end else if (m_pend) begin
      if (svalid[m_sel]) begin
        m_pend <= 0; m_resp <= 1;
        e_valid <= 1; e_busy <= 0; e_err <= 0; e_data <= slave_word(m_sel);
      end else if (TO_EN && (m_waited + 1 == TO)) begin
        m_pend <= 0; m_resp <= 1;
        e_valid <= 1; e_busy <= 0; e_err <= 1; e_data <= 32'hDEAD_BEEF;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (read) begin
      if (int'(sel) < NS) begin
        m_pend <= 1; m_sel <= int'(sel); m_waited <= 0; e_busy <= 1;
      end else begin
        m_resp <= 1; e_valid <= 1; e_err <= 1; e_data <= 32'hDEAD_BEEF;
      end
    end
  end

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          chk_en = 0;
  int          lit_at = -1;
  string       lit_name;
  logic        lit_v, lit_b, lit_e;
  logic [31:0] lit_d;

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ({valid, busy, err, data} !== {e_valid, e_busy, e_err, e_data}) begin
        bad++;
        $display("FAIL model cyc=%0d got v=%b b=%b e=%b d=%h want v=%b b=%b e=%b d=%h",
                 cyc, valid, busy, err, data, e_valid, e_busy, e_err, e_data);
      end
    end
    if (cyc == lit_at) begin
      total++;
      if ({valid, busy, err, data} !== {lit_v, lit_b, lit_e, lit_d}) begin
        bad++;
        $display("FAIL %s cyc=%0d got v=%b b=%b e=%b d=%h want v=%b b=%b e=%b d=%h",
                 lit_name, cyc, valid, busy, err, data, lit_v, lit_b, lit_e, lit_d);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pins the outputs expected at the next negedge to hand-computed literals.
  task automatic pin(input string name, input logic v, input logic b, input logic e,
                     input logic [31:0] d);
    lit_name = name; lit_v = v; lit_b = b; lit_e = e; lit_d = d;
    lit_at = cyc;
  endtask

  task automatic set_slv(input int k, input logic [31:0] w);
    sdata[k*DW +: DW] = w;
    svalid[k] = 1'b1;
  endtask

  initial begin
    rst_n = 0; read = 0; sel = '0; sdata = '0; svalid = '0;
    tick(); tick();
    chk_en = 1;
    pin("reset", 0, 0, 0, 32'h0);
    rst_n = 1;
    tick();
    pin("idle_no_read", 0, 0, 0, 32'h0);
    tick();

    // Zero-wait UART read
    sel = SW'(SLV_UART); read = 1; tick();
    read = 0; set_slv(SLV_UART, 32'h0000_0041);
    pin("uart_busy", 0, 1, 0, 32'h0);
    tick();
    svalid = '0;
    pin("uart_resp", 1, 0, 0, 32'h0000_0041);
    tick();
    pin("uart_hold", 0, 0, 0, 32'h0000_0041);
    tick();

    // Switch read with stray RAM valids; sel_i change after acceptance is ignored
    sel = SW'(SLV_SW); read = 1; tick();
    read = 0; sel = SW'(SLV_RAM);
    for (int i = 0; i < 5; i++) begin
      svalid = '0; set_slv(SLV_RAM, $urandom);
      pin("stray_busy", 0, 1, 0, 32'h0000_0041);
      tick();
    end
    svalid = '0; set_slv(SLV_SW, 32'h0000_00A5);
    pin("sw_last_wait", 0, 1, 0, 32'h0000_0041);
    tick();
    svalid = '0;
    pin("sw_resp", 1, 0, 0, 32'h0000_00A5);
    tick();

`ifdef BUS_READ_MUX_TIMEOUT_EN
    sel = SW'(SLV_SW); read = 1; tick();
    read = 0;
    for (int i = 0; i < TO; i++) begin
      pin("to_busy", 0, 1, 0, 32'h0000_00A5);
      tick();
    end
    pin("to_err", 1, 0, 1, 32'hDEAD_BEEF);
    tick();
    sel = SW'(SLV_SW); read = 1; tick();
    read = 0;
    for (int i = 0; i < TO - 1; i++) begin
      pin("to_edge_busy", 0, 1, 0, 32'hDEAD_BEEF);
      tick();
    end
    set_slv(SLV_SW, 32'h5A5A_0F0F);
    pin("to_edge_last", 0, 1, 0, 32'hDEAD_BEEF);
    tick();
    svalid = '0;
    pin("to_edge_valid", 1, 0, 0, 32'h5A5A_0F0F);
    tick();
`else
    sel = SW'(SLV_SW); read = 1; tick();
    read = 0;
    for (int i = 0; i < 20; i++) begin
      pin("long_wait_busy", 0, 1, 0, 32'h0000_00A5);
      tick();
    end
    set_slv(SLV_SW, 32'h0BAD_F00D);
    tick();
    svalid = '0;
    pin("long_wait_resp", 1, 0, 0, 32'h0BAD_F00D);
    tick();
`endif

    // Bad select, with read_i held through RESP
    sel = SW'(SLV_GAUSS); read = 1; tick();
    sel = SW'(SLV_RAM);
    pin("bad_sel", 1, 0, 1, 32'hDEAD_BEEF);
    tick();
    pin("resp_ignores_read", 0, 0, 0, 32'hDEAD_BEEF);
    tick();
    read = 0; set_slv(SLV_RAM, 32'hCAFE_0001);
    pin("rearm_busy", 0, 1, 0, 32'hDEAD_BEEF);
    tick();
    svalid = '0;
    pin("ram_resp", 1, 0, 0, 32'hCAFE_0001);
    tick();

    // Reset in the middle of WAIT drops the request
    sel = SW'(SLV_UART); read = 1; tick();
    read = 0; rst_n = 0;
    pin("rst_wait_busy", 0, 1, 0, 32'hCAFE_0001);
    tick();
    rst_n = 1; set_slv(SLV_UART, 32'h0000_0077);
    pin("rst_cleared", 0, 0, 0, 32'h0);
    tick();
    svalid = '0; sel = SW'(SLV_RAM); read = 1;
    pin("rst_no_resp", 0, 0, 0, 32'h0);
    tick();
    read = 0; set_slv(SLV_RAM, 32'h1234_5678);
    tick();
    svalid = '0;
    pin("after_rst", 1, 0, 0, 32'h1234_5678);
    tick();

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      read  = $urandom_range(0, 1);
      sel   = SW'($urandom_range(0, 3));
      for (int k = 0; k < NS; k++) begin
        sdata[k*DW +: DW] = $urandom;
        svalid[k] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    rst_n = 1; read = 0; svalid = '0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
